// File: rtl/weight_fetch_scheduler.sv
// weight_fetch_scheduler
//   Sequences weight fetches from a BRAM read controller into a registered
//   output word for the MAC array. A job is cfg_passes passes of cfg_words
//   words each. Every pass starts with an address_reset pulse so the
//   controller re-reads from address 0.
//
// Ports
//   clk, rst            single clock, synchronous active-high reset
//   start, abort        job control; abort wins over everything
//   cfg_words/passes    job shape, captured on an accepted start
//   address_reset       zeroes the controller's address and FSM
//   read_en, read_len   consume the presented word; 1 = fetch an A+B pair
//   data_valid          controller presents a valid word on weight_in
//   mac_weight(_valid)  registered word to the MAC array
//   mac_ready           MAC array takes mac_weight this cycle
//   busy, done          job in flight / one-cycle completion pulse

// One MAC lane's slice of the output register. It loads whenever a word is
// consumed, so every lane of mac_weight always comes from the same word.
module wfs_lane #(
  parameter int LW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [LW-1:0] d,
  output logic [LW-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst)       q <= '0;
    else if (load) q <= d;
  end
endmodule

module weight_fetch_scheduler #(
  parameter int MAC_NUM   = 256,
  parameter int CNT_WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CNT_WIDTH-1:0] cfg_words,
  input  logic [CNT_WIDTH-1:0] cfg_passes,
  output logic                 address_reset,
  output logic                 read_en,
  output logic                 read_len,
  input  logic                 data_valid,
  input  logic [5*MAC_NUM-1:0] weight_in,
  output logic [5*MAC_NUM-1:0] mac_weight,
  output logic                 mac_weight_valid,
  input  logic                 mac_ready,
  output logic                 busy,
  output logic                 done
);

  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] TWO = CNT_WIDTH'(2);

  typedef enum logic [2:0] {
    IDLE,
    ADDR_RST,
    FETCH,
    DRAIN,
    FINISH
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   words_left;
  logic [CNT_WIDTH-1:0]   passes_left;
  logic [CNT_WIDTH-1:0]   words_cfg_q;
  logic                   ar_q;

  logic start_ok;
  logic cfg_zero;
  logic out_free;
  logic last_read;
  logic drain_exit;
  logic more_passes;

  // A start only counts from IDLE, and never in the same cycle as abort.
  assign start_ok    = (state_q == IDLE) & start & ~abort;
  assign cfg_zero    = (cfg_words == '0) | (cfg_passes == '0);

  // The output register can take a new word if it is empty or being
  // handed off this very cycle (gives one word per cycle when streaming).
  assign out_free    = ~mac_weight_valid | mac_ready;

  // rst gates read_en so nothing is consumed before the state register
  // has been forced back to IDLE.
  assign read_en     = ~rst & (state_q == FETCH) & data_valid &
                       (words_left != '0) & out_free;
  assign read_len    = (words_left >= TWO);

  assign last_read   = read_en & (words_left == ONE);
  assign drain_exit  = (state_q == DRAIN) & out_free;
  assign more_passes = (passes_left > ONE);

  assign busy = (state_q == ADDR_RST) | (state_q == FETCH) | (state_q == DRAIN);
  assign done = (state_q == FINISH);

  // ar_q stretches address_reset one cycle past rst falling and covers the
  // cycle after an abort; the rst term keeps it high before the first edge.
  assign address_reset = rst | ar_q | (state_q == ADDR_RST);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start_ok) state_d = cfg_zero ? FINISH : ADDR_RST;
      ADDR_RST: state_d = FETCH;
      FETCH:    if (last_read) state_d = DRAIN;
      DRAIN:    if (out_free) state_d = more_passes ? ADDR_RST : FINISH;
      FINISH:   state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) ar_q <= 1'b1;
    else     ar_q <= abort;
  end

  // ------------------------------------------------------------ counters
  // words_left is loaded directly from cfg_words on the first ADDR_RST
  // entry (the latch is being written in the same edge) and from the
  // latched copy on later pass boundaries. Both counters stop at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      words_left  <= '0;
      passes_left <= '0;
      words_cfg_q <= '0;
    end else if (abort) begin
      words_left  <= '0;
      passes_left <= '0;
    end else if (start_ok) begin
      words_cfg_q <= cfg_words;
      words_left  <= cfg_zero ? '0 : cfg_words;
      passes_left <= cfg_zero ? '0 : cfg_passes;
    end else begin
      if (drain_exit && more_passes)
        words_left <= words_cfg_q;
      else if (read_en && (words_left != '0))
        words_left <= words_left - ONE;
      if (drain_exit && (passes_left != '0))
        passes_left <= passes_left - ONE;
    end
  end

  // -------------------------------------------------------- output stage
  always_ff @(posedge clk) begin
    if (rst || abort)   mac_weight_valid <= 1'b0;
    else if (read_en)   mac_weight_valid <= 1'b1;
    else if (mac_ready) mac_weight_valid <= 1'b0;
  end

  for (genvar i = 0; i < MAC_NUM; i++) begin : g_lane
    wfs_lane #(.LW(5)) u_lane (
      .clk  (clk),
      .rst  (rst),
      .load (read_en),
      .d    (weight_in[i*5 +: 5]),
      .q    (mac_weight[i*5 +: 5])
    );
  end

endmodule

// File: tb/tb_weight_fetch_scheduler.sv
// Bench for weight_fetch_scheduler: a small BRAM controller model presents
// word_at(addr); expected words and read_len values are queued when a job is
// started and popped as the DUT hands off / reads.
module tb_weight_fetch_scheduler;
  localparam int MN = 4;
  localparam int CW = 8;
  localparam int W  = 5 * MN;

  logic          clk = 1'b0;
  logic          rst, start, abort;
  logic [CW-1:0] cfg_words, cfg_passes;
  logic          address_reset, read_en, read_len;
  logic          data_valid;
  logic [W-1:0]  weight_in, mac_weight;
  logic          mac_weight_valid, mac_ready, busy, done;

  logic dv_en, dv_rand, dv_rnd;
  int   addr = 0;

  int checks = 0, failures = 0;
  int handoff_cnt, rd_cnt, done_cnt, ar_cnt, stall_cnt;
  logic [W-1:0] exp_word[$];
  logic         exp_len[$];

  weight_fetch_scheduler #(.MAC_NUM(MN), .CNT_WIDTH(CW)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .abort            (abort),
    .cfg_words        (cfg_words),
    .cfg_passes       (cfg_passes),
    .address_reset    (address_reset),
    .read_en          (read_en),
    .read_len         (read_len),
    .data_valid       (data_valid),
    .weight_in        (weight_in),
    .mac_weight       (mac_weight),
    .mac_weight_valid (mac_weight_valid),
    .mac_ready        (mac_ready),
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] word_at(input int a);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < MN; i++) w[i*5 +: 5] = 5'(a*3 + i*7 + 1);
    return w;
  endfunction

  // BRAM read controller model
  always @(posedge clk) begin
    if (address_reset) addr <= 0;
    else if (read_en)  addr <= addr + 1;
  end
  assign weight_in  = word_at(addr);
  assign data_valid = dv_en & dv_rnd;

  initial begin
    dv_rnd = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      dv_rnd = dv_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: scoreboard pops, stall-hold checks and event tallies.
  initial begin
    logic         prev_stall;
    logic [W-1:0] prev_w;
    prev_stall = 1'b0;
    prev_w     = '0;
    forever begin
      @(negedge clk);
      if (mac_weight_valid && mac_ready) begin
        handoff_cnt++;
        if (exp_word.size() == 0) check("handoff_unexpected", 1, 0);
        else                      check("handoff_word", mac_weight, exp_word.pop_front());
      end
      if (read_en) begin
        rd_cnt++;
        if (exp_len.size() == 0) check("read_unexpected", 1, 0);
        else                     check("read_len", read_len, exp_len.pop_front());
      end
      if (done)          done_cnt++;
      if (address_reset) ar_cnt++;
      if (prev_stall) begin
        check("stall_valid_hold", mac_weight_valid, 1);
        check("stall_word_hold", mac_weight, prev_w);
      end
      if (mac_weight_valid && !mac_ready) begin
        stall_cnt++;
        check("stall_read_en", read_en, 0);
      end
      prev_stall = mac_weight_valid & ~mac_ready;
      prev_w     = mac_weight;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    handoff_cnt = 0; rd_cnt = 0; done_cnt = 0; ar_cnt = 0; stall_cnt = 0;
  endtask

  task automatic flush();
    exp_word.delete();
    exp_len.delete();
  endtask

  task automatic start_job(input int w, input int p);
    for (int pi = 0; pi < p; pi++)
      for (int k = 0; k < w; k++) begin
        exp_word.push_back(word_at(k));
        exp_len.push_back((w - k) >= 2);
      end
    cfg_words  = CW'(w);
    cfg_passes = CW'(p);
    start = 1'b1;
    tick();
    start = 1'b0;
    cfg_words  = 8'hAA;
    cfg_passes = 8'h55;
  endtask

  task automatic wait_done(input string tag, input int max, output int n);
    n = 0;
    while (!done && n < max) begin
      tick();
      n++;
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_busy_at_done"}, busy, 0);
  endtask

  task automatic wait_handoffs(input string tag, input int target);
    int n;
    n = 0;
    while (handoff_cnt < target && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_reached"}, handoff_cnt >= target, 1);
  endtask

  task automatic finish_job(input string tag, input int handoffs, input int ars);
    tick();
    check({tag, "_done_pulse_end"}, done, 0);
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_queue_empty"}, exp_word.size(), 0);
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_handoffs"}, handoff_cnt, handoffs);
    check({tag, "_addr_resets"}, ar_cnt, ars);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    cfg_words = '0; cfg_passes = '0;
    mac_ready = 1'b1; dv_en = 1'b1; dv_rand = 1'b0;
    clear_counts();

    // reset state
    repeat (2) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", mac_weight_valid, 0);
    check("rst_read_en", read_en, 0);
    check("rst_mac_weight", mac_weight, 0);
    check("rst_addr_reset", address_reset, 1);
    rst = 1'b0;
    check("rst_fall_addr_reset", address_reset, 1);
    tick();
    check("rst_fall_addr_reset_end", address_reset, 0);

    // 4 words, 1 pass, streaming
    clear_counts();
    start_job(4, 1);
    check("j1_busy", busy, 1);
    check("j1_addr_reset", address_reset, 1);
    wait_done("j1", 200, n);
    finish_job("j1", 4, 1);
    check("j1_reads", rd_cnt, 4);

    // 3 words, 2 passes, gappy data_valid
    clear_counts();
    dv_rand = 1'b1;
    start_job(3, 2);
    wait_done("j2", 400, n);
    check("j2_handoffs_at_done", handoff_cnt, 6);
    finish_job("j2", 6, 2);
    dv_rand = 1'b0;

    // 5 words with a 3-cycle MAC stall after the 2nd word
    clear_counts();
    start_job(5, 1);
    wait_handoffs("j3", 2);
    mac_ready = 1'b0;
    repeat (3) tick();
    mac_ready = 1'b1;
    wait_done("j3", 200, n);
    finish_job("j3", 5, 1);
    check("j3_stall_cycles", stall_cnt, 3);

    // zero-sized jobs
    clear_counts();
    start_job(0, 3);
    wait_done("j4", 10, n);
    check("j4_latency", n, 0);
    finish_job("j4", 0, 0);
    check("j4_reads", rd_cnt, 0);
    clear_counts();
    start_job(5, 0);
    wait_done("j4b", 10, n);
    check("j4b_latency", n, 0);
    finish_job("j4b", 0, 0);

    // abort after the 2nd word, then a fresh job from address 0
    clear_counts();
    start_job(6, 1);
    wait_handoffs("j5", 2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("j5_busy", busy, 0);
    check("j5_valid", mac_weight_valid, 0);
    check("j5_addr_reset", address_reset, 1);
    check("j5_done", done, 0);
    flush();
    repeat (4) tick();
    check("j5_no_done", done_cnt, 0);
    check("j5_addr_reset_end", address_reset, 0);
    clear_counts();
    start_job(2, 1);
    wait_done("j5b", 200, n);
    finish_job("j5b", 2, 1);

    // start pulsed while busy is ignored
    clear_counts();
    start_job(3, 2);
    tick();
    cfg_words = 8'd7; cfg_passes = 8'd5; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("j6", 400, n);
    finish_job("j6", 6, 2);

    // mid-job reset
    clear_counts();
    start_job(4, 2);
    wait_handoffs("j7", 1);
    rst = 1'b1;
    tick();
    check("j7_busy", busy, 0);
    check("j7_valid", mac_weight_valid, 0);
    check("j7_mac_weight", mac_weight, 0);
    check("j7_read_en", read_en, 0);
    check("j7_done", done, 0);
    rst = 1'b0;
    flush();
    check("j7_fall_addr_reset", address_reset, 1);
    repeat (3) tick();
    check("j7_no_done", done_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
